// File: rtl/calc_key_driver_pkg.sv
// Shared types and constants for the calculator key driver: key encoding,
// request kinds and the response error-vector bit positions.
package calc_key_driver_pkg;

  typedef enum logic [3:0] {
    OP_IDLE  = 4'h0,
    OP_START = 4'h1,
    OP_ENTER = 4'h2,
    OP_ARITH = 4'h3,
    OP_DONE  = 4'h4
  } oper_t;

  typedef struct packed {
    oper_t       op;
    logic [15:0] payload;
  } keyIn_t;

  typedef enum logic [1:0] {
    KIND_VALUE = 2'd0,
    KIND_OP    = 2'd1,
    KIND_END   = 2'd2,
    KIND_RSVD  = 2'd3
  } req_kind_t;

  typedef struct packed {
    req_kind_t   kind;
    logic [15:0] payload;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } drv_state_t;

  localparam keyIn_t      IDLE_KEY     = '{op: OP_IDLE, payload: 16'h0000};
  localparam logic [15:0] DONE_PAYLOAD = 16'h0001;
  localparam logic [3:0]  MAX_DEPTH    = 4'd8;
  localparam int          REQ_W        = $bits(req_t);

  // rsp_err bit positions
  localparam int ERR_STACK_OVF  = 3;
  localparam int ERR_UNEXP_DONE = 2;
  localparam int ERR_PROTOCOL   = 1;
  localparam int ERR_DATA_OVF   = 0;

endpackage

// File: rtl/calc_key_driver_req_fifo.sv
// Request buffer for the key driver: power-of-two depth FIFO with
// show-ahead read data; a push into a full FIFO is refused even when popping.
module calc_req_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d   = rd_ptr_q + (AW+1)'(do_pop);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/calc_key_driver.sv
// Sequences buffered requests into calculator keys and captures the response.
// Define CALC_DRV_CHECK_EN to drop out-of-sequence requests instead of sending them.
//   state    | meaning
//   IDLE     | no expression open; VALUE opens one with START
//   STREAM   | expression open; VALUE->ENTER, OP->ARITH_OP, END->DONE
//   WAIT_RSP | DONE sent, waiting for finished or timeout
//   RESP     | response presented until rsp_ready
module calc_key_driver
  import calc_key_driver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_kind_i,
  input  logic [15:0] req_payload_i,
  output logic [19:0] data_o,
  input  logic [15:0] result_i,
  input  logic        correct_i,
  input  logic        finished_i,
  input  logic        stack_overflow_i,
  input  logic        unexpected_done_i,
  input  logic        protocol_error_i,
  input  logic        data_overflow_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_result_o,
  output logic        rsp_correct_o,
  output logic [3:0]  rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        seq_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CALC_DRV_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  drv_state_t  state_q, state_d;
  keyIn_t      data_q, data_d;
  logic [3:0]  depth_q, depth_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        rsp_correct_q, rsp_correct_d;
  logic [3:0]  rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        seq_error_q, seq_error_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [REQ_W-1:0] fifo_rdata;
  req_t             head;
  logic             in_idle;
  logic [3:0]       err_in;

  calc_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (req_valid_i),
    .push_data_i ({req_kind_i, req_payload_i}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head        = req_t'(fifo_rdata);
  assign req_ready_o = !fifo_full;

  always_comb begin
    err_in                 = '0;
    err_in[ERR_STACK_OVF]  = stack_overflow_i;
    err_in[ERR_UNEXP_DONE] = unexpected_done_i;
    err_in[ERR_PROTOCOL]   = protocol_error_i;
    err_in[ERR_DATA_OVF]   = data_overflow_i;
  end

  always_comb begin
    state_d       = state_q;
    data_d        = IDLE_KEY;
    depth_d       = depth_q;
    timer_d       = timer_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_correct_d = rsp_correct_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    seq_error_d   = 1'b0;
    fifo_pop      = 1'b0;
    in_idle       = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (head.kind)
            KIND_VALUE: begin
              if (CHECK_EN && (depth_q == MAX_DEPTH)) begin
                seq_error_d = 1'b1;
              end else begin
                data_d.op      = in_idle ? OP_START : OP_ENTER;
                data_d.payload = head.payload;
                if (depth_q != MAX_DEPTH) depth_d = depth_q + 4'd1;
                state_d = ST_STREAM;
              end
            end
            KIND_OP: begin
              if (CHECK_EN && (in_idle || (depth_q < 4'd2))) begin
                seq_error_d = 1'b1;
              end else begin
                data_d.op      = OP_ARITH;
                data_d.payload = head.payload;
                if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
              end
            end
            KIND_END: begin
              if (CHECK_EN && (in_idle || (depth_q != 4'd1))) begin
                seq_error_d = 1'b1;
              end else begin
                data_d.op      = OP_DONE;
                data_d.payload = DONE_PAYLOAD;
                // An unchecked END while idle is sent for error injection only.
                if (!in_idle) begin
                  state_d = ST_WAIT_RSP;
                  timer_d = TW'(TIMEOUT_CYCLES);
                end
              end
            end
            default: seq_error_d = 1'b1;
          endcase
        end
      end

      ST_WAIT_RSP: begin
        if (finished_i) begin
          rsp_result_d  = result_i;
          rsp_correct_d = correct_i;
          rsp_err_d     = err_in;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (timer_q <= TW'(1)) begin
          rsp_result_d  = '0;
          rsp_correct_d = 1'b0;
          rsp_err_d     = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          depth_d     = 4'd0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      data_q        <= IDLE_KEY;
      depth_q       <= 4'd0;
      timer_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_correct_q <= 1'b0;
      rsp_err_q     <= '0;
      rsp_timeout_q <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      depth_q       <= depth_d;
      timer_q       <= timer_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_correct_q <= rsp_correct_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign data_o        = data_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_correct_o = rsp_correct_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign seq_error_o   = seq_error_q;

endmodule

// File: tb/tb_calc_key_driver.sv
// Randomized bench for calc_key_driver: a request-level model predicts the key
// stream, seq_error count and response; a bench-side calculator answers DONE.
module tb_calc_key_driver;
  import calc_key_driver_pkg::*;

  localparam int TMO = 16;

`ifdef CALC_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_kind_i = 2'd0;
  logic [15:0] req_payload_i = 16'd0;
  logic [19:0] data_o;
  logic [15:0] result_i = 16'd0;
  logic        correct_i = 1'b0;
  logic        finished_i = 1'b0;
  logic [3:0]  err_i = 4'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_result_o;
  logic        rsp_correct_o;
  logic [3:0]  rsp_err_o;
  logic        rsp_timeout_o;
  logic        seq_error_o;

  calc_key_driver #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_kind_i        (req_kind_i),
    .req_payload_i     (req_payload_i),
    .data_o            (data_o),
    .result_i          (result_i),
    .correct_i         (correct_i),
    .finished_i        (finished_i),
    .stack_overflow_i  (err_i[3]),
    .unexpected_done_i (err_i[2]),
    .protocol_error_i  (err_i[1]),
    .data_overflow_i   (err_i[0]),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .rsp_correct_o     (rsp_correct_o),
    .rsp_err_o         (rsp_err_o),
    .rsp_timeout_o     (rsp_timeout_o),
    .seq_error_o       (seq_error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] obs[$];
  int          seq_cnt = 0;
  int          key_base, seq_base;

  logic [1:0]  rq_kind[$];
  logic [15:0] rq_pay[$];
  logic [19:0] exp_keys[$];
  int          exp_seq;

  int          calc_w;
  logic [15:0] calc_result;
  logic        calc_correct;
  logic [3:0]  calc_err;
  bit          bg_done;

  always @(negedge clk) begin
    if (data_o[19:16] != 4'h0) obs.push_back(data_o);
    if (seq_error_o) seq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] key(input logic [3:0] op, input logic [15:0] p);
    return {op, p};
  endfunction

  // Request-level model of the key stream the calculator should see.
  task automatic model_build();
    bit streaming = 1'b0;
    int depth = 0;
    exp_keys.delete();
    exp_seq = 0;
    foreach (rq_kind[i]) begin
      case (rq_kind[i])
        2'd0: if (CHK && depth == 8) exp_seq++;
              else begin
                exp_keys.push_back(key(streaming ? 4'(OP_ENTER) : 4'(OP_START), rq_pay[i]));
                streaming = 1'b1;
                if (depth < 8) depth++;
              end
        2'd1: if (CHK && (!streaming || depth < 2)) exp_seq++;
              else begin
                exp_keys.push_back(key(4'(OP_ARITH), rq_pay[i]));
                if (depth > 0) depth--;
              end
        2'd2: if (CHK && (!streaming || depth != 1)) exp_seq++;
              else begin
                exp_keys.push_back(key(4'(OP_DONE), 16'h0001));
                if (streaming) begin streaming = 1'b0; depth = 0; end
              end
        default: exp_seq++;
      endcase
    end
  endtask

  task automatic push_req(input logic [1:0] k, input logic [15:0] p);
    int tmo = 0;
    req_valid_i = 1'b1;
    req_kind_i = k;
    req_payload_i = p;
    while (!req_ready_o && tmo < 300) begin @(negedge clk); tmo++; end
    if (tmo >= 300) chk("push_wait", tmo, 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic add_req(input logic [1:0] k, input logic [15:0] p);
    rq_kind.push_back(k);
    rq_pay.push_back(p);
  endtask

  task automatic mark();
    key_base = obs.size();
    seq_base = seq_cnt;
    rq_kind.delete();
    rq_pay.delete();
  endtask

  task automatic responder();
    int cnt = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (data_o[19:16] == 4'(OP_DONE)) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    if (!seen) return;
    while (!rsp_valid_o && cnt < 60) begin
      finished_i = (calc_w < TMO) && (cnt == calc_w);
      @(negedge clk);
      cnt++;
    end
    finished_i = 1'b0;
    chk("rsp_latency", cnt, (calc_w < TMO) ? calc_w + 1 : TMO);
  endtask

  task automatic check_rsp(input string tag);
    if (calc_w < TMO) begin
      chk({tag, "_result"}, rsp_result_o, calc_result);
      chk({tag, "_correct"}, rsp_correct_o, calc_correct);
      chk({tag, "_err"}, rsp_err_o, calc_err);
      chk({tag, "_timeout"}, rsp_timeout_o, 0);
    end else begin
      chk({tag, "_timeout"}, rsp_timeout_o, 1);
      chk({tag, "_correct"}, rsp_correct_o, 0);
    end
  endtask

  // Pushes rq_* from index skip onward, answers DONE, checks and releases
  // the response, then compares the key stream since the last mark().
  task automatic run_txn(input int skip, input int hold);
    model_build();
    result_i = calc_result;
    correct_i = calc_correct;
    err_i = calc_err;
    fork
      begin
        for (int i = skip; i < rq_kind.size(); i++) begin
          push_req(rq_kind[i], rq_pay[i]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      responder();
    join
    check_rsp("rsp");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", rsp_valid_o, 1);
      check_rsp("rsp_hold");
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_release", rsp_valid_o, 0);
    repeat (3) @(negedge clk);
    chk("key_count", obs.size() - key_base, exp_keys.size());
    for (int i = 0; i < exp_keys.size() && key_base + i < obs.size(); i++)
      chk("key", obs[key_base + i], exp_keys[i]);
    chk("seq_err_cnt", seq_cnt - seq_base, exp_seq);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_result", rsp_result_o, 0);
    chk("rst_rsp_flags", {rsp_correct_o, rsp_err_o, rsp_timeout_o}, 0);
    chk("rst_seq_error", seq_error_o, 0);

    // Basic expression with latency into an empty FIFO.
    mark();
    add_req(0, 16'd5); add_req(0, 16'd3); add_req(1, 16'd1); add_req(2, 16'd0);
    calc_w = 2; calc_result = 16'd8; calc_correct = 1'b1; calc_err = 4'd0;
    push_req(0, 16'd5);
    @(negedge clk);
    chk("lat_pre", data_o, 0);
    @(negedge clk);
    chk("lat_start", data_o, key(4'(OP_START), 16'd5));
    run_txn(1, 2);

    // FIFO stall while waiting for a response that times out.
    mark();
    add_req(0, 16'd1); add_req(2, 16'd0);
    add_req(0, 16'd2); add_req(0, 16'd3); add_req(1, 16'd1); add_req(0, 16'd4); add_req(1, 16'd2);
    add_req(2, 16'd0);
    push_req(0, 16'd1);
    push_req(2, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (data_o[19:16] == 4'(OP_DONE)) seen = 1'b1;
    end
    chk("stall_done_seen", 32'(seen), 1);
    bg_done = 1'b0;
    fork
      begin
        push_req(0, 16'd2); push_req(0, 16'd3); push_req(1, 16'd1);
        push_req(0, 16'd4); push_req(1, 16'd2);
        bg_done = 1'b1;
      end
    join_none
    cnt = 0;
    while (!rsp_valid_o && cnt < 60) begin @(negedge clk); cnt++; end
    chk("tmo_latency", cnt, TMO);
    chk("tmo_flag", rsp_timeout_o, 1);
    chk("tmo_correct", rsp_correct_o, 0);
    chk("stall_ready", req_ready_o, 0);
    chk("stall_pending", req_valid_i, 1);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("tmo_release", rsp_valid_o, 0);
    cnt = 0;
    while (!bg_done && cnt < 100) begin @(negedge clk); cnt++; end
    chk("stall_drain", 32'(bg_done), 1);
    calc_w = 6; calc_result = 16'd77; calc_correct = 1'b1; calc_err = 4'd0;
    run_txn(7, 1);

    // OP while idle: dropped with checks, sent verbatim without.
    mark();
    push_req(1, 16'd1);
    @(negedge clk);
    @(negedge clk);
    chk("idle_op_data", data_o, CHK ? 20'h0 : key(4'(OP_ARITH), 16'd1));
    chk("idle_op_seq", seq_error_o, CHK ? 1 : 0);
    repeat (2) @(negedge clk);

    // Protocol error response held until accepted.
    mark();
    add_req(0, 16'd9); add_req(2, 16'd0);
    calc_w = 3; calc_result = 16'h1234; calc_correct = 1'b0; calc_err = 4'b0010;
    run_txn(0, 3);

    // finished on the last allowed cycle, then one cycle too late.
    mark();
    add_req(0, 16'd4); add_req(0, 16'd6); add_req(1, 16'd3); add_req(2, 16'd0);
    calc_w = TMO - 1; calc_result = 16'd24; calc_correct = 1'b1; calc_err = 4'b1000;
    run_txn(0, 0);
    mark();
    add_req(0, 16'd4); add_req(3, 16'd7); add_req(2, 16'd0);
    calc_w = TMO; calc_result = 16'd4; calc_correct = 1'b1; calc_err = 4'b0000;
    run_txn(0, 1);

    // Randomized expressions with reserved kinds sprinkled in.
    for (int t = 0; t < 12; t++) begin
      int n;
      mark();
      if ($urandom_range(0, 2) == 0) add_req(1, 16'($urandom_range(0, 65535)));
      add_req(0, 16'($urandom_range(0, 65535)));
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 4) == 0) add_req(3, 16'($urandom_range(0, 65535)));
        add_req(0, 16'($urandom_range(0, 65535)));
        add_req(1, 16'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 3) == 0) add_req(3, 16'd0);
      add_req(2, 16'($urandom_range(0, 65535)));
      calc_w = $urandom_range(0, 19);
      calc_result = 16'($urandom_range(0, 65535));
      calc_correct = 1'($urandom_range(0, 1));
      calc_err = 4'($urandom_range(0, 15));
      run_txn(0, $urandom_range(0, 3));
    end

    // Reset in the middle of a stream discards everything buffered.
    push_req(0, 16'd1);
    push_req(0, 16'd2);
    push_req(0, 16'd3);
    push_req(0, 16'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_data", data_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    key_base = obs.size();
    repeat (10) @(negedge clk);
    chk("midrst_no_keys", obs.size() - key_base, 0);
    chk("midrst_ready", req_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_key_driver.md
CALC_KEY_DRIVER -- requirements
Module: calc_key_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles to wait for finished after DONE is sent.
REQ-002 Parameter FIFO_DEPTH, default 4: request buffer entries, power of two.
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1 / req_ready  out  1  request handshake; transfer when both are high at a rising edge.
REQ-006 req_kind  in  2  VALUE=0, OP=1, END=2; 3 reserved.
REQ-007 req_payload  in  16  operand, or ARITH_OP code.
REQ-008 data  out  20  keyIn_t (op, payload) to calculator.
REQ-009 result  in  16 / correct  in  1 / finished  in  1 / stackOverflow, unexpectedDone, protocolError, dataOverflow  in  1 each  calculator outputs.
REQ-010 rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-011 rsp_result  out  16 / rsp_correct  out  1 / rsp_err  out  4 {stackOverflow, unexpectedDone, protocolError, dataOverflow} / rsp_timeout  out  1.
REQ-012 seq_error  out  1  one-cycle pulse per rejected request.

Function
REQ-013 Requests SHALL enter a FIFO_DEPTH FIFO; req_ready = !full, a push is refused when full even if a pop occurs in the same cycle.
REQ-014 FSM states SHALL be IDLE, STREAM, WAIT_RSP and RESP.
REQ-015 In IDLE/STREAM one entry SHALL be popped per cycle when the FIFO is non-empty; data is registered, giving 2-cycle latency from acceptance into an empty FIFO.
REQ-016 The mapping SHALL be: VALUE in IDLE -> START, then STREAM; VALUE in STREAM -> ENTER; OP -> ARITH_OP; END -> DONE, then WAIT_RSP.
REQ-017 payload SHALL be req_payload unchanged; DONE payload SHALL be 16'h0001.
REQ-018 Any cycle with no key to send SHALL drive IDLE_KEY (op 4'h0, payload 0).
REQ-019 The module SHALL keep a depth counter (0..8): START/ENTER +1, ARITH_OP -1, cleared on return to IDLE.
REQ-020 WAIT_RSP SHALL pop nothing and count cycles; finished=1 SHALL capture result, correct and the error flags into rsp_*, clear rsp_timeout and move to RESP.
REQ-021 If TIMEOUT_CYCLES cycles pass without finished, rsp_timeout=1, rsp_correct=0, and the FSM SHALL move to RESP.
REQ-022 In RESP, rsp_valid=1 and rsp_* SHALL hold stable until rsp_ready; that cycle returns to IDLE.
REQ-023 Reserved req_kind SHALL be dropped with a seq_error pulse in all builds.

Reset
REQ-024 Asynchronous reset SHALL force IDLE, empty FIFO, depth 0, data=IDLE_KEY, rsp_valid=0, rsp_*=0, seq_error=0, and req_ready=1 on the first edge after release.
REQ-025 Reset mid-stream SHALL discard all buffered requests and any pending response.

Configuration
REQ-026 With CALC_DRV_CHECK_EN defined, these SHALL be dropped with a seq_error pulse and not sent: OP or END in IDLE, OP with depth<2, VALUE with depth=8, and END with depth!=1.
REQ-027 Without CALC_DRV_CHECK_EN, every non-reserved request SHALL be sent verbatim (OP/END in IDLE sent as ARITH_OP/DONE without a state change), allowing error injection; seq_error then only flags reserved kinds.

Structure
REQ-028 Shared package SHALL hold oper_t, keyIn_t, req_kind_t, the IDLE_KEY constant and the err-vector bit indices.
REQ-029 The FIFO SHALL be the sub-module calc_req_fifo (parameterised width/depth); the FSM and response capture stay in calc_key_driver.

Verification
REQ-030 VALUE 5, VALUE 3, OP 1, END; calculator returns finished, correct=1, result=8 -> data sequence START 5, ENTER 3, ARITH_OP 1, DONE 1; rsp_result=8, rsp_correct=1.
REQ-031 Five back-to-back requests without rsp_ready -> req_ready low after 4 accepted with the FIFO stalled; no request is lost.
REQ-032 With CHECK_EN: OP 1 while IDLE -> seq_error pulse, data stays IDLE_KEY; without CHECK_EN -> ARITH_OP 1 sent.
REQ-033 END sent, finished held low -> rsp_valid with rsp_timeout=1 exactly 16 cycles after DONE.
REQ-034 Reset asserted while in STREAM with 3 entries queued -> data=IDLE_KEY immediately, nothing sent after release.
REQ-035 finished=1 with protocolError=1 -> rsp_err=4'b0010, held until rsp_ready.
